// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the data-memory responder.
// Word width, controller states, access kinds and latched request.
package mem_pkg;

   localparam int WORD_SIZE = 16;

   typedef enum logic {
      IDLE,
      BUSY
   } mem_state_t;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } mem_op_t;

   typedef struct packed {
      logic [WORD_SIZE-1:0] addr;
      logic [WORD_SIZE-1:0] wrdata;
      mem_op_t              op;
   } mem_req_t;

   // Write wins when both request lines are high.
   function automatic mem_op_t req_op(input logic wr);
      return wr ? OP_WRITE : OP_READ;
   endfunction

endpackage

// File: rtl/sp_ram.sv
// sp_ram: single-port synchronous word RAM.
// Read-first, one cycle read latency, no reset of contents.
module sp_ram #(
   parameter int WORD_SIZE = 16,
   parameter int DEPTH     = 256
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WORD_SIZE-1:0]     wdata,
   output logic [WORD_SIZE-1:0]     rdata
);

   logic [WORD_SIZE-1:0] mem [DEPTH];

   // Write on enable, register the addressed word every cycle.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-port memory slave with fixed wait states.
// Optional ReadCount/WriteCount outputs: define DATA_MEM_STATS_EN.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [WORD_SIZE-1:0] Addr,
   input  logic [WORD_SIZE-1:0] WrData,
   input  logic                 Write,
   input  logic                 Read,
   output logic [WORD_SIZE-1:0] RdData,
   output logic                 Waitreq,
   output logic                 ProtoErr
`ifdef DATA_MEM_STATS_EN
   ,
   output logic [WORD_SIZE-1:0] ReadCount,
   output logic [WORD_SIZE-1:0] WriteCount
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int WS = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
   localparam int CW = (WS > 1) ? $clog2(WS) : 1;

   mem_state_t           state;
   mem_state_t           state_nxt;
   logic [CW-1:0]        cnt;
   mem_req_t             req_l;
   logic [WORD_SIZE-1:0] rd_hold;
   logic [WORD_SIZE-1:0] ram_rdata;
   logic [AW-1:0]        ram_addr;
   logic                 req;
   logic                 last;
   logic                 done;
   logic                 ram_we;
   logic                 proto_hit;
   mem_op_t              cur_op;

   assign req    = Read | Write;
   assign cur_op = req_op(Write);
   assign last   = (state == BUSY) && (cnt == '0);

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state: accept from IDLE, leave BUSY on completion or drop.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (req) state_nxt = BUSY;
         BUSY: if (!req || cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: stall, RAM port and read data bypass on completion.
   always_comb begin
      Waitreq  = 1'b0;
      done     = 1'b0;
      ram_we   = 1'b0;
      ram_addr = Addr[AW-1:0];
      RdData   = rd_hold;
      if (state == BUSY) ram_addr = req_l.addr[AW-1:0];
      if (!Reset) begin
         Waitreq = req & ~last;
         done    = req & last;
         ram_we  = done & (req_l.op == OP_WRITE);
         if (done && req_l.op == OP_READ) RdData = ram_rdata;
      end
   end

   // Protocol checks: dual op, dropped request, unstable request.
   always_comb begin
      proto_hit = Read & Write;
      if (state == BUSY) begin
         if (!req) begin
            proto_hit = 1'b1;
         end else if (Waitreq &&
                      (Addr != req_l.addr ||
                       WrData != req_l.wrdata ||
                       cur_op != req_l.op)) begin
            proto_hit = 1'b1;
         end
      end
   end

   // Request latch, wait counter, held read data, sticky error.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt      <= '0;
         req_l    <= '0;
         rd_hold  <= '0;
         ProtoErr <= 1'b0;
      end else begin
         if (state == IDLE && req) begin
            req_l.addr   <= Addr;
            req_l.wrdata <= WrData;
            req_l.op     <= cur_op;
            cnt          <= CW'(WS - 1);
         end else if (state == BUSY && req && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (done && req_l.op == OP_READ) rd_hold <= ram_rdata;
         if (proto_hit) ProtoErr <= 1'b1;
      end
   end

`ifdef DATA_MEM_STATS_EN
   // Saturating counts of completed accesses.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         ReadCount  <= '0;
         WriteCount <= '0;
      end else if (done) begin
         if (req_l.op == OP_READ) begin
            if (ReadCount != '1)
               ReadCount <= ReadCount + WORD_SIZE'(1);
         end else if (WriteCount != '1) begin
            WriteCount <= WriteCount + WORD_SIZE'(1);
         end
      end
   end
`endif

   sp_ram #(
      .WORD_SIZE(WORD_SIZE),
      .DEPTH    (DEPTH)
   ) u_ram (
      .clk  (Clock),
      .we   (ram_we),
      .addr (ram_addr),
      .wdata(req_l.wrdata),
      .rdata(ram_rdata)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: two responders (2 and 1 wait states),
// directed tables, hand sequences and random traffic vs an array model.
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst;
   logic [1:0]       rd_s;
   logic [1:0]       wr_s;
   logic [1:0]       wq;
   logic [1:0]       pe;
   logic [1:0][15:0] addr_s;
   logic [1:0][15:0] wd_s;
   logic [1:0][15:0] rdd;
`ifdef DATA_MEM_STATS_EN
   logic [1:0][15:0] rcnt;
   logic [1:0][15:0] wcnt;
`endif

   data_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut0 (
      .Clock   (clk),
      .Reset   (rst[0]),
      .Addr    (addr_s[0]),
      .WrData  (wd_s[0]),
      .Write   (wr_s[0]),
      .Read    (rd_s[0]),
      .RdData  (rdd[0]),
      .Waitreq (wq[0]),
      .ProtoErr(pe[0])
`ifdef DATA_MEM_STATS_EN
      ,
      .ReadCount (rcnt[0]),
      .WriteCount(wcnt[0])
`endif
   );

   data_mem_responder #(.DEPTH(256), .WAIT_STATES(1)) dut1 (
      .Clock   (clk),
      .Reset   (rst[1]),
      .Addr    (addr_s[1]),
      .WrData  (wd_s[1]),
      .Write   (wr_s[1]),
      .Read    (rd_s[1]),
      .RdData  (rdd[1]),
      .Waitreq (wq[1]),
      .ProtoErr(pe[1])
`ifdef DATA_MEM_STATS_EN
      ,
      .ReadCount (rcnt[1]),
      .WriteCount(wcnt[1])
`endif
   );

   typedef struct {
      bit          rd;
      bit          wr;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp;
      int          gap;
   } vec_t;

   int          nvec = 0;
   int          nerr = 0;
   int          ws [2];
   logic [15:0] mdl [2][256];
   logic [15:0] last_rd [2];
   bit          exp_pe [2];
   vec_t        tbl [9];

   task automatic chk(input string nm, input int k,
                      input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s dut%0d: got %h want %h at %0t",
                  nm, k, act, exp, $time);
      end
   endtask

   // Idle cycles: no stall, read data held, error flag as modelled.
   task automatic idle(input int k, input int n);
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_waitreq", k, 16'(wq[k]), 16'd0);
         chk("idle_rddata", k, rdd[k], last_rd[k]);
         chk("idle_protoerr", k, 16'(pe[k]), 16'(exp_pe[k]));
         @(posedge clk);
         #1;
      end
   endtask

   // One access held until completion: stall for ws cycles, then done.
   task automatic acc(input int k, input bit rd, input bit wr,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp, input bit chg,
                      input logic [15:0] ca);
      rd_s[k]   = rd;
      wr_s[k]   = wr;
      addr_s[k] = a;
      wd_s[k]   = d;
      if ((rd && wr) || chg) exp_pe[k] = 1'b1;
      for (int c = 0; c <= ws[k]; c++) begin
         @(negedge clk);
         chk("acc_waitreq", k, 16'(wq[k]), (c < ws[k]) ? 16'd1 : 16'd0);
         if (c == ws[k]) begin
            chk("acc_protoerr", k, 16'(pe[k]), 16'(exp_pe[k]));
            if (!wr) chk("acc_rddata", k, rdd[k], exp);
         end
         @(posedge clk);
         #1;
         if (c == 0 && chg) addr_s[k] = ca;
      end
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b0;
      if (wr) mdl[k][a[7:0]] = d;
      else    last_rd[k] = exp;
   endtask

   // Request dropped after one stalled cycle.
   task automatic abort_acc(input int k, input bit wr,
                            input logic [15:0] a, input logic [15:0] d);
      rd_s[k]   = !wr;
      wr_s[k]   = wr;
      addr_s[k] = a;
      wd_s[k]   = d;
      @(negedge clk);
      chk("abort_waitreq_hi", k, 16'(wq[k]), 16'd1);
      @(posedge clk);
      #1;
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b0;
      @(negedge clk);
      chk("abort_waitreq_lo", k, 16'(wq[k]), 16'd0);
      chk("abort_rddata", k, rdd[k], last_rd[k]);
      chk("abort_pe_before", k, 16'(pe[k]), 16'(exp_pe[k]));
      @(posedge clk);
      #1;
      exp_pe[k] = 1'b1;
   endtask

   task automatic reset_k(input int k);
      rst[k]  = 1'b1;
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b0;
      @(posedge clk);
      #1;
      rst[k]     = 1'b0;
      last_rd[k] = 16'h0;
      exp_pe[k]  = 1'b0;
      idle(k, 1);
`ifdef DATA_MEM_STATS_EN
      chk("rst_readcount", k, rcnt[k], 16'd0);
      chk("rst_writecount", k, wcnt[k], 16'd0);
`endif
   endtask

   initial begin
      logic [15:0] a;
      logic [15:0] d;
      logic [7:0]  hi;
      ws[0] = 2;
      ws[1] = 1;
      tbl[0] = '{0, 1, 16'h0010, 16'hBEEF, 16'h0000, 1};
      tbl[1] = '{1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0};
      tbl[2] = '{0, 1, 16'h0105, 16'h1234, 16'h0000, 0};
      tbl[3] = '{1, 0, 16'h0005, 16'h0000, 16'h1234, 1};
      tbl[4] = '{0, 1, 16'h00FF, 16'hA5A5, 16'h0000, 0};
      tbl[5] = '{1, 0, 16'h01FF, 16'h0000, 16'hA5A5, 0};
      tbl[6] = '{1, 0, 16'h0010, 16'h0000, 16'hBEEF, 2};
      tbl[7] = '{0, 1, 16'hFF10, 16'h0001, 16'h0000, 0};
      tbl[8] = '{1, 0, 16'h0010, 16'h0000, 16'h0001, 1};

      rst    = 2'b11;
      rd_s   = 2'b00;
      wr_s   = 2'b00;
      addr_s = '0;
      wd_s   = '0;
      for (int k = 0; k < 2; k++) begin
         last_rd[k] = 16'h0;
         exp_pe[k]  = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 2'b00;
      idle(0, 1);
      idle(1, 1);
`ifdef DATA_MEM_STATS_EN
      chk("init_readcount", 0, rcnt[0], 16'd0);
      chk("init_writecount", 0, wcnt[0], 16'd0);
`endif

      // Directed table: basic, back-to-back, wrap, overwrite.
      for (int i = 0; i < 9; i++) begin
         acc(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d,
             tbl[i].exp, 1'b0, 16'h0);
         idle(0, tbl[i].gap);
      end

      // Random traffic on 16 words with random wrapped upper bits.
      for (int i = 0; i < 16; i++)
         acc(0, 1'b0, 1'b1, 16'(i), 16'($urandom), 16'h0, 1'b0, 16'h0);
      for (int i = 0; i < 150; i++) begin
         hi = 8'($urandom_range(0, 255));
         a  = {hi, 4'h0, 4'($urandom_range(0, 15))};
         d  = 16'($urandom);
         if ($urandom_range(0, 1) == 1)
            acc(0, 1'b0, 1'b1, a, d, 16'h0, 1'b0, 16'h0);
         else
            acc(0, 1'b1, 1'b0, a, 16'h0, mdl[0][a[7:0]], 1'b0, 16'h0);
         idle(0, int'($urandom_range(0, 2)));
      end

      // Aborted read, then a working write/read pair.
      abort_acc(0, 1'b0, 16'h0020, 16'h0);
      idle(0, 1);
      acc(0, 1'b0, 1'b1, 16'h0021, 16'h6789, 16'h0, 1'b0, 16'h0);
      acc(0, 1'b1, 1'b0, 16'h0021, 16'h0, 16'h6789, 1'b0, 16'h0);
      idle(0, 1);

      // Address change mid-wait on a plain write.
      reset_k(0);
      acc(0, 1'b0, 1'b1, 16'h0050, 16'h1111, 16'h0, 1'b0, 16'h0);
      acc(0, 1'b0, 1'b1, 16'h0051, 16'h2222, 16'h0, 1'b0, 16'h0);
      idle(0, 1);
      exp_pe[0] = 1'b0;
      acc(0, 1'b0, 1'b1, 16'h0050, 16'h3333, 16'h0, 1'b1, 16'h0051);
      idle(0, 1);
      acc(0, 1'b1, 1'b0, 16'h0050, 16'h0, 16'h3333, 1'b0, 16'h0);
      acc(0, 1'b1, 1'b0, 16'h0051, 16'h0, 16'h2222, 1'b0, 16'h0);

      // Dual op plus address change.
      reset_k(0);
      acc(0, 1'b0, 1'b1, 16'h0031, 16'h7777, 16'h0, 1'b0, 16'h0);
      acc(0, 1'b1, 1'b1, 16'h0030, 16'h00AA, 16'h0, 1'b1, 16'h0031);
      idle(0, 1);
      acc(0, 1'b1, 1'b0, 16'h0030, 16'h0, 16'h00AA, 1'b0, 16'h0);
      acc(0, 1'b1, 1'b0, 16'h0031, 16'h0, 16'h7777, 1'b0, 16'h0);

      // Reset in the first busy cycle of a write.
      reset_k(0);
      acc(0, 1'b0, 1'b1, 16'h0040, 16'h0BAD, 16'h0, 1'b0, 16'h0);
      acc(0, 1'b1, 1'b0, 16'h0040, 16'h0, 16'h0BAD, 1'b0, 16'h0);
      wr_s[0]   = 1'b1;
      addr_s[0] = 16'h0040;
      wd_s[0]   = 16'h5555;
      @(negedge clk);
      chk("rstw_waitreq_hi", 0, 16'(wq[0]), 16'd1);
      @(posedge clk);
      #1;
      rst[0] = 1'b1;
      @(negedge clk);
      chk("rstw_waitreq_in_reset", 0, 16'(wq[0]), 16'd0);
      @(posedge clk);
      #1;
      rst[0]     = 1'b0;
      wr_s[0]    = 1'b0;
      last_rd[0] = 16'h0;
      exp_pe[0]  = 1'b0;
      @(negedge clk);
      chk("rstw_waitreq", 0, 16'(wq[0]), 16'd0);
      chk("rstw_rddata", 0, rdd[0], 16'h0);
      chk("rstw_protoerr", 0, 16'(pe[0]), 16'd0);
      @(posedge clk);
      #1;
      acc(0, 1'b1, 1'b0, 16'h0040, 16'h0, 16'h0BAD, 1'b0, 16'h0);
      idle(0, 1);

      // One wait state: 3 reads, 2 writes with one aborted.
      acc(1, 1'b0, 1'b1, 16'h0005, 16'h1111, 16'h0, 1'b0, 16'h0);
      abort_acc(1, 1'b1, 16'h0005, 16'h2222);
      acc(1, 1'b1, 1'b0, 16'h0005, 16'h0, 16'h1111, 1'b0, 16'h0);
      acc(1, 1'b1, 1'b0, 16'h0105, 16'h0, 16'h1111, 1'b0, 16'h0);
      acc(1, 1'b1, 1'b0, 16'h0205, 16'h0, 16'h1111, 1'b0, 16'h0);
      idle(1, 1);
`ifdef DATA_MEM_STATS_EN
      chk("readcount", 1, rcnt[1], 16'd3);
      chk("writecount", 1, wcnt[1], 16'd1);
`endif

      // Pure dual op with one wait state.
      reset_k(1);
      acc(1, 1'b1, 1'b1, 16'h0030, 16'h00AA, 16'h0, 1'b0, 16'h0);
      idle(1, 1);
      acc(1, 1'b1, 1'b0, 16'h0030, 16'h0, 16'h00AA, 1'b0, 16'h0);
      idle(1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
